// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: state encoding for the IDLE/RUN/DONE sequencer and the default
// operand width used by the interface, the step datapath and the top level.
package divider_pkg;

    localparam int unsigned DEFAULT_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Handshake and data bundle between a divider and its controller.
// Signals:
//   i_start, i_dividend, i_divisor           request side (controller -> divider)
//   o_busy, o_finished, o_quotient,
//   o_remainder, o_div_by_zero               result side (divider -> controller)
// Modports: master (controller), slave (divider).
interface divider_if
    import divider_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) ();

    logic            i_start;
    logic [BITS-1:0] i_dividend;
    logic [BITS-1:0] i_divisor;
    logic            o_busy;
    logic            o_finished;
    logic [BITS-1:0] o_quotient;
    logic [BITS-1:0] o_remainder;
    logic            o_div_by_zero;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_busy, o_finished, o_quotient, o_remainder, o_div_by_zero
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_busy, o_finished, o_quotient, o_remainder, o_div_by_zero
    );

endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step.
// Ports:
//   rem       in   BITS  partial remainder before the step
//   dvd_msb   in   1     dividend bit shifted into the remainder
//   divisor   in   BITS  divisor
//   rem_next  out  BITS  partial remainder after the step
//   q_bit     out  1     quotient bit produced by the step
module divider_step
    import divider_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic [BITS-1:0] rem,
    input  logic            dvd_msb,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] rem_next,
    output logic            q_bit
);

    // One bit wider than the operands so a set remainder MSB cannot overflow.
    logic [BITS:0] shifted;
    logic [BITS:0] dvs_ext;

    always_comb begin
        shifted = {rem, dvd_msb};
        dvs_ext = {1'b0, divisor};
        q_bit   = (shifted >= dvs_ext);
        // After a successful subtract the result is below the divisor, so it
        // always fits in BITS bits.
        rem_next = q_bit ? BITS'(shifted - dvs_ext) : shifted[BITS-1:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   i_clock    in  rising-edge clock
//   i_reset_n  in  asynchronous active-low reset
//   bus        divider_if.slave: start/operands in; busy, finished pulse,
//              quotient, remainder and divide-by-zero flag out
// Results are held until the next accepted start; divide by zero returns an
// all-ones quotient and the dividend as remainder.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic     i_clock,
    input  logic     i_reset_n,
    divider_if.slave bus
);

    state_t          state_q, state_d;
    logic [BITS-1:0] cnt_q, cnt_d;       // one-hot step counter
    logic [BITS-1:0] rem_q, rem_d;       // partial remainder
    logic [BITS-1:0] dvd_q, dvd_d;       // dividend, shifted out MSB first
    logic [BITS-1:0] dvs_q, dvs_d;       // latched divisor
    logic [BITS-1:0] quo_q, quo_d;       // quotient bits collected so far
    logic [BITS-1:0] quotient_q, quotient_d;
    logic [BITS-1:0] remainder_q, remainder_d;
    logic            dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            finished_q, finished_d;

    logic [BITS-1:0] step_rem;
    logic            step_q_bit;
    logic [BITS-1:0] quo_next;

    divider_step #(.BITS(BITS)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[BITS-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q_bit)
    );

    assign quo_next = (quo_q << 1) | BITS'(step_q_bit);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        finished_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    dvd_d = bus.i_dividend;
                    dvs_d = bus.i_divisor;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = BITS'(1);
                    if (bus.i_divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.i_dividend;
                        dz_d        = 1'b1;
                        finished_d  = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                dvd_d = dvd_q << 1;
                quo_d = quo_next;
                cnt_d = cnt_q << 1;
                if (cnt_q[BITS-1]) begin
                    quotient_d  = quo_next;
                    remainder_d = step_rem;
                    dz_d        = 1'b0;
                    finished_d  = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_finished    = finished_q;
    assign bus.o_quotient    = quotient_q;
    assign bus.o_remainder   = remainder_q;
    assign bus.o_div_by_zero = dz_q;

endmodule
